uart_msg_scheduler: RTL and testbench

//   Shares one byte-level UART transmitter among NREQ requesters. Each request is a 32-bit word.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_msg_scheduler_rr_arbiter.sv | 42 ++++
 rtl/uart_msg_scheduler.sv | 168 ++++++++++++++++
 tb/tb_uart_msg_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART message scheduler.
//   ASCII_CR / ASCII_LF : trailer bytes appended after each word
//   state_e             : scheduler FSM states
//   word_byte()         : pick byte i (0 = LSB) out of a 32-bit word
package uart_pkg;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_CR, S_LF} state_e;

   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] i);
      return w[8*i +: 8];
   endfunction

endpackage

// File: rtl/uart_msg_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req        in  N    request vector
//   ptr        in  IW   highest-priority index this round
//   gnt_onehot out N    one-hot grant (zero when no request)
//   gnt_idx    out IW   index of granted requester
//   any        out 1    at least one request present
module rr_arbiter #(
   parameter int N = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt_onehot,
   output logic [IW-1:0] gnt_idx,
   output logic          any
);

   logic [IW:0]   s;
   logic [IW-1:0] j;

   // Scan offsets from farthest to nearest so the nearest set bit at or
   // after ptr is the last one written and therefore wins.
   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      any        = 1'b0;
      s          = '0;
      j          = '0;
      for (int k = N-1; k >= 0; k--) begin
         s = {1'b0, ptr} + (IW+1)'(k);
         if (s >= (IW+1)'(N)) s = s - (IW+1)'(N);
         j = s[IW-1:0];
         if (req[j]) begin
            gnt_onehot    = '0;
            gnt_onehot[j] = 1'b1;
            gnt_idx       = j;
            any           = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_msg_scheduler.sv
// uart_msg_scheduler: shares one byte-wide UART transmitter among NREQ
// requesters. A granted 32-bit word is sent MSB byte first (low WORD_BYTES
// bytes), optionally followed by CR LF. Grants rotate round-robin.
//   clk, rst   clock / asynchronous active-high reset
//   req        per-requester request level, held until ack
//   req_data   word i at [32*i+31:32*i]
//   ack        one-cycle one-hot pulse: word captured
//   done       one-cycle pulse after the last byte of a message transfers
//   tx_data    byte to serializer, tx_valid qualifies it, tx_ready accepts
//   busy       message in progress
//   cur_id     requester being served (valid while busy)
module uart_msg_scheduler
   import uart_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter int WORD_BYTES  = 4,
   parameter int APPEND_CRLF = 1,
   localparam int IW = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*32-1:0]   req_data,
   output logic [NREQ-1:0]      ack,
   output logic                 done,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic                 busy,
   output logic [IW-1:0]        cur_id
);

   localparam logic [1:0] IDX_TOP = 2'(WORD_BYTES-1);

   state_e          state_q, state_d;
   logic [31:0]     word_q, word_d;
   logic [1:0]      idx_q, idx_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic            done_q, done_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_valid_q, tx_valid_d;
   logic            busy_q, busy_d;
   logic [IW-1:0]   cur_id_q, cur_id_d;

   logic [NREQ-1:0] gnt_oh;
   logic [IW-1:0]   gnt_idx;
   logic            gnt_any;
   logic [31:0]     sel_word;
   logic            hs;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req        (req),
      .ptr        (ptr_q),
      .gnt_onehot (gnt_oh),
      .gnt_idx    (gnt_idx),
      .any        (gnt_any)
   );

   always_comb begin
      sel_word = '0;
      for (int i = 0; i < NREQ; i++)
         if (gnt_oh[i]) sel_word = req_data[32*i +: 32];
   end

   assign hs = tx_valid_q & tx_ready;

   // tx_data/tx_valid are registered and only change on a handshake (or the
   // grant), so a presented byte is never retracted or altered.
   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      idx_d      = idx_q;
      ptr_d      = ptr_q;
      ack_d      = '0;
      done_d     = 1'b0;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      busy_d     = busy_q;
      cur_id_d   = cur_id_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_any) begin
               word_d     = sel_word;
               cur_id_d   = gnt_idx;
               ack_d      = gnt_oh;
               ptr_d      = (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + IW'(1);
               idx_d      = IDX_TOP;
               state_d    = S_SEND;
               busy_d     = 1'b1;
               tx_valid_d = 1'b1;
               tx_data_d  = word_byte(sel_word, IDX_TOP);
            end
         end
         S_SEND: begin
            if (hs) begin
               if (idx_q != 2'd0) begin
                  idx_d     = idx_q - 2'd1;
                  tx_data_d = word_byte(word_q, idx_q - 2'd1);
               end else if (APPEND_CRLF != 0) begin
                  state_d   = S_CR;
                  tx_data_d = ASCII_CR;
               end else begin
                  state_d    = S_IDLE;
                  busy_d     = 1'b0;
                  tx_valid_d = 1'b0;
                  tx_data_d  = '0;
                  done_d     = 1'b1;
               end
            end
         end
         S_CR: begin
            if (hs) begin
               state_d   = S_LF;
               tx_data_d = ASCII_LF;
            end
         end
         S_LF: begin
            if (hs) begin
               state_d    = S_IDLE;
               busy_d     = 1'b0;
               tx_valid_d = 1'b0;
               tx_data_d  = '0;
               done_d     = 1'b1;
            end
         end
         default: begin
            state_d    = S_IDLE;
            busy_d     = 1'b0;
            tx_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         word_q     <= '0;
         idx_q      <= '0;
         ptr_q      <= '0;
         ack_q      <= '0;
         done_q     <= 1'b0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         cur_id_q   <= '0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         idx_q      <= idx_d;
         ptr_q      <= ptr_d;
         ack_q      <= ack_d;
         done_q     <= done_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
         cur_id_q   <= cur_id_d;
      end
   end

   assign ack      = ack_q;
   assign done     = done_q;
   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign busy     = busy_q;
   assign cur_id   = cur_id_q;

endmodule

// File: tb/tb_uart_msg_scheduler.sv
// Bench for uart_msg_scheduler: queue-based reference model of the byte
// stream and round-robin grant order, directed scenarios plus random traffic.
module tb_uart_msg_scheduler;

   localparam int NREQ = 4;

   logic              clk, rst;
   logic [NREQ-1:0]   req;
   logic [NREQ*32-1:0] req_data;
   logic [NREQ-1:0]   ack;
   logic              done, tx_valid, tx_ready, busy;
   logic [7:0]        tx_data;
   logic [1:0]        cur_id;

   // second instance: 2-byte words, no trailer
   logic [NREQ-1:0]   req2;
   logic [NREQ*32-1:0] req_data2;
   logic [NREQ-1:0]   ack2;
   logic              done2, tx_valid2, tx_ready2, busy2;
   logic [7:0]        tx_data2;
   logic [1:0]        cur_id2;

   uart_msg_scheduler #(.NREQ(NREQ), .WORD_BYTES(4), .APPEND_CRLF(1)) u_dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .done(done),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .cur_id(cur_id));

   uart_msg_scheduler #(.NREQ(NREQ), .WORD_BYTES(2), .APPEND_CRLF(0)) u_dut2 (
      .clk(clk), .rst(rst), .req(req2), .req_data(req_data2), .ack(ack2), .done(done2),
      .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .busy(busy2), .cur_id(cur_id2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ptr_m  = 0;
   bit auto_drop = 1'b1;
   int ack_cnt [NREQ];
   int done_cnt = 0;
   logic [7:0] exp_q [$];
   logic [7:0] sent_log [$];
   int grant_log [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++)
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   // One clock: inputs are already set; capture what the next posedge will
   // see, then check the outputs at the following negedge against the model.
   task automatic cycle();
      logic [NREQ-1:0]    s_req;
      logic [NREQ*32-1:0] s_rd;
      logic               s_valid, s_ready, hs, exp_done;
      logic [7:0]         s_data;
      logic [NREQ-1:0]    exp_ack;
      bit                 idle;
      int                 w;
      s_req = req; s_rd = req_data; s_valid = tx_valid; s_ready = tx_ready; s_data = tx_data;
      idle = (exp_q.size() == 0);
      @(negedge clk);
      hs = s_valid && s_ready;
      exp_done = 1'b0;
      if (hs) begin
         sent_log.push_back(s_data);
         if (exp_q.size() == 0) chk("hs_unexpected", 32'(s_data), 32'hFFFF_FFFF);
         else begin
            chk("hs_byte", 32'(s_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            exp_done = (exp_q.size() == 0);
         end
      end
      exp_ack = '0;
      w = -1;
      if (!rst && idle && |s_req) begin
         w = rr_pick(s_req, ptr_m);
         exp_ack[w] = 1'b1;
         ptr_m = (w + 1) % NREQ;
         for (int b = 3; b >= 0; b--) exp_q.push_back(s_rd[32*w + 8*b +: 8]);
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
         grant_log.push_back(w);
      end
      chk("ack", 32'(ack), 32'(exp_ack));
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(exp_q.size() != 0));
      chk("tx_valid", 32'(tx_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("tx_data", 32'(tx_data), 32'(exp_q[0]));
      if (w >= 0) chk("cur_id", 32'(cur_id), 32'(w));
      if (s_valid && !s_ready) begin
         chk("hold_valid", 32'(tx_valid), 32'd1);
         chk("hold_data", 32'(tx_data), 32'(s_data));
      end
      for (int i = 0; i < NREQ; i++) if (ack[i]) ack_cnt[i]++;
      if (done) done_cnt++;
      if (auto_drop) req = req & ~ack;
   endtask

   task automatic drain(input int bound);
      int n = 0;
      while ((exp_q.size() != 0 || |req) && n < bound) begin
         cycle();
         n++;
      end
      if (n >= bound) chk("drain_timeout", 32'(n), 32'(bound - 1));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      exp_q.delete();
      ptr_m = 0;
      cycle();
      cycle();
      rst = 1'b0;
      cycle();
   endtask

   task automatic set_word(input int i, input logic [31:0] w);
      req_data[32*i +: 32] = w;
   endtask

   initial begin
      logic [7:0] t1 [6];
      int n, t78, tdone, acks2;
      logic [7:0] log2 [$];
      t1 = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};

      rst = 1'b1; req = '0; req_data = '0; tx_ready = 1'b0;
      req2 = '0; req_data2 = '0; tx_ready2 = 1'b0;
      for (int i = 0; i < NREQ; i++) ack_cnt[i] = 0;
      #1;
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cur_id", 32'(cur_id), 32'd0);
      cycle();
      rst = 1'b0;
      cycle();

      // 1: single word with trailer
      tx_ready = 1'b1;
      set_word(0, 32'h41424344);
      req[0] = 1'b1;
      sent_log.delete();
      drain(50);
      chk("t1_nbytes", 32'(sent_log.size()), 32'd6);
      for (int i = 0; i < 6 && i < sent_log.size(); i++) chk("t1_byte", 32'(sent_log[i]), 32'(t1[i]));
      chk("t1_ack_cnt", 32'(ack_cnt[0]), 32'd1);
      chk("t1_done_cnt", 32'(done_cnt), 32'd1);

      // 2: all requesters held -> strict rotation
      do_reset();
      auto_drop = 1'b0;
      for (int i = 0; i < NREQ; i++) set_word(i, 32'h30303030 + 32'(i));
      grant_log.delete();
      req = '1;
      n = 0;
      while (grant_log.size() < 4 && n < 200) begin cycle(); n++; end
      req = '0;
      auto_drop = 1'b1;
      drain(50);
      chk("t2_ngrants", 32'(grant_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("t2_order", 32'(grant_log[i]), 32'(i));

      // 3: pointer after serving 3 wraps to 0
      grant_log.delete();
      set_word(3, 32'hA1B2C3D4);
      set_word(0, 32'h5A5A0F0F);
      req = 4'b1000;
      drain(50);
      req = 4'b1001;
      drain(100);
      chk("t3_ngrants", 32'(grant_log.size()), 32'd3);
      if (grant_log.size() == 3) begin
         chk("t3_g0", 32'(grant_log[0]), 32'd3);
         chk("t3_g1", 32'(grant_log[1]), 32'd0);
         chk("t3_g2", 32'(grant_log[2]), 32'd3);
      end

      // 4: backpressure on byte 0x42
      set_word(0, 32'h41424344);
      sent_log.delete();
      req[0] = 1'b1;
      n = 0;
      while (!(tx_valid && tx_data == 8'h42) && n < 20) begin cycle(); n++; end
      chk("t4_reach42", 32'(tx_data), 32'h42);
      tx_ready = 1'b0;
      repeat (50) begin
         cycle();
         chk("t4_stall_v", 32'(tx_valid), 32'd1);
         chk("t4_stall_d", 32'(tx_data), 32'h42);
      end
      tx_ready = 1'b1;
      drain(50);
      chk("t4_nbytes", 32'(sent_log.size()), 32'd6);
      for (int i = 0; i < 6 && i < sent_log.size(); i++) chk("t4_byte", 32'(sent_log[i]), 32'(t1[i]));

      // 5: asynchronous reset mid-byte
      req[0] = 1'b1;
      n = 0;
      while (!(tx_valid && tx_data == 8'h42) && n < 20) begin cycle(); n++; end
      tx_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("t5_async_valid", 32'(tx_valid), 32'd0);
      chk("t5_async_busy", 32'(busy), 32'd0);
      exp_q.delete();
      ptr_m = 0;
      req = '0;
      cycle();
      cycle();
      rst = 1'b0;
      tx_ready = 1'b1;
      repeat (3) cycle();
      grant_log.delete();
      req = 4'b1001;
      drain(100);
      chk("t5_ngrants", 32'(grant_log.size()), 32'd2);
      if (grant_log.size() == 2) begin
         chk("t5_g0", 32'(grant_log[0]), 32'd0);
         chk("t5_g1", 32'(grant_log[1]), 32'd3);
      end

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         tx_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i]) begin
               if ($urandom_range(0, 7) == 0) begin
                  req_data[32*i +: 32] = $urandom;
                  req[i] = 1'b1;
               end
            end else if ($urandom_range(0, 99) == 0) begin
               req[i] = 1'b0;
            end
         end
         cycle();
      end
      req = '0;
      tx_ready = 1'b1;
      drain(100);

      // 6: 2-byte words, no trailer
      req_data2[31:0] = 32'h12345678;
      tx_ready2 = 1'b1;
      req2[0] = 1'b1;
      t78 = -1; tdone = -1; acks2 = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done2) tdone = k;
         if (ack2[0]) begin req2[0] = 1'b0; acks2++; end
         if (tx_valid2) begin
            log2.push_back(tx_data2);
            if (tx_data2 == 8'h78) t78 = k;
         end
      end
      chk("t6_nbytes", 32'(log2.size()), 32'd2);
      if (log2.size() == 2) begin
         chk("t6_b0", 32'(log2[0]), 32'h56);
         chk("t6_b1", 32'(log2[1]), 32'h78);
      end
      chk("t6_done_time", 32'(tdone), 32'(t78 + 1));
      chk("t6_acks", 32'(acks2), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
